vx_tb_mem_responder: RTL

//  Line-granular memory model answering the core's L1 memory-arbiter requests in the socket bench.

---
 rtl/vx_tb_mem_responder.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vx_tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vx_tb_mem_responder                                             |
// | Purpose  : Line-granular memory model answering L1 memory-arbiter requests |
// |            with tagged, fixed-latency read responses; includes a preload   |
// |            port that owns the array while load_en is high.                 |
// | Options  : VX_TB_MEM_WRITE_RSP_EN - writes also return a zero-data rsp.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vx_tb_mem_responder #(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 512,
   parameter int TAG_WIDTH  = 8,
   parameter int NUM_LINES  = 4096,
   parameter int LATENCY    = 4,
   parameter int RSP_QUEUE  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load_en,
   input  logic                          load_valid,
   input  logic [ADDR_WIDTH-1:0]         load_addr,
   input  logic [DATA_WIDTH-1:0]         load_data,
   output logic                          load_done,
   input  logic                          mem_req_valid,
   input  logic                          mem_req_rw,
   input  logic [ADDR_WIDTH-1:0]         mem_req_addr,
   input  logic [DATA_WIDTH/8-1:0]       mem_req_byteen,
   input  logic [DATA_WIDTH-1:0]         mem_req_data,
   input  logic [TAG_WIDTH-1:0]          mem_req_tag,
   output logic                          mem_req_ready,
   output logic                          mem_rsp_valid,
   output logic [DATA_WIDTH-1:0]         mem_rsp_data,
   output logic [TAG_WIDTH-1:0]          mem_rsp_tag,
   input  logic                          mem_rsp_ready,
   output logic [$clog2(RSP_QUEUE):0]    outstanding
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int OUT_W = $clog2(RSP_QUEUE) + 1;
   localparam int PTR_W = $clog2(RSP_QUEUE);

   localparam logic [0:0] ST_LOAD  = 1'b0;
   localparam logic [0:0] ST_SERVE = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [OUT_W-1:0]      outstanding_q, outstanding_d;
   logic [DATA_WIDTH-1:0] mem_q [NUM_LINES];

   logic                  req_fire, slot_fire, rsp_pop;
   logic [IDX_W-1:0]      req_idx;
   logic                  pin_valid, fin_valid;
   logic [DATA_WIDTH-1:0] pin_data, fin_data;
   logic [TAG_WIDTH-1:0]  pin_tag, fin_tag;

   logic                  wr_en;
   logic [IDX_W-1:0]      wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [BYTES-1:0]      wr_be;

   logic                  unused_addr_bits;
   assign unused_addr_bits = ^{mem_req_addr[ADDR_WIDTH-1:IDX_W], load_addr[ADDR_WIDTH-1:IDX_W]};

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_LOAD;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:  if (!load_en) state_d = ST_SERVE;
         ST_SERVE: if (load_en && outstanding_q == '0) state_d = ST_LOAD;
         default:  state_d = ST_LOAD;
      endcase
   end

   always_comb begin
      load_done     = (state_q == ST_SERVE);
      mem_req_ready = (state_q == ST_SERVE) && !load_en && (outstanding_q < OUT_W'(RSP_QUEUE));
   end

   // ---------------- Request side ----------------
   assign req_fire = mem_req_valid & mem_req_ready;
   assign req_idx  = mem_req_addr[IDX_W-1:0];
   assign rsp_pop  = mem_rsp_valid & mem_rsp_ready;

`ifdef VX_TB_MEM_WRITE_RSP_EN
   assign slot_fire = req_fire;
`else
   assign slot_fire = req_fire & ~mem_req_rw;
`endif

   assign pin_valid = slot_fire;
   assign pin_data  = mem_req_rw ? '0 : mem_q[req_idx];
   assign pin_tag   = mem_req_tag;

   // Loader and request writes never coincide: requests are only accepted in SERVE.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = load_addr[IDX_W-1:0];
      wr_data = load_data;
      wr_be   = '1;
      if (state_q == ST_LOAD && load_valid) begin
         wr_en = 1'b1;
      end else if (req_fire && mem_req_rw) begin
         wr_en   = 1'b1;
         wr_idx  = req_idx;
         wr_data = mem_req_data;
         wr_be   = mem_req_byteen;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wr_be[b]) mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   // ---------------- Latency pipe (LATENCY-1 stages; FIFO output adds the last) ----------------
   generate
      if (LATENCY > 1) begin : g_pipe
         localparam int DEPTH = LATENCY - 1;
         logic [DEPTH-1:0]      vld_q, vld_d;
         logic [DATA_WIDTH-1:0] dat_q [DEPTH];
         logic [DATA_WIDTH-1:0] dat_d [DEPTH];
         logic [TAG_WIDTH-1:0]  tag_q [DEPTH];
         logic [TAG_WIDTH-1:0]  tag_d [DEPTH];

         always_comb begin
            vld_d[0] = pin_valid;
            dat_d[0] = pin_data;
            tag_d[0] = pin_tag;
            for (int i = 1; i < DEPTH; i++) begin
               vld_d[i] = vld_q[i-1];
               dat_d[i] = dat_q[i-1];
               tag_d[i] = tag_q[i-1];
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) vld_q <= '0;
            else       vld_q <= vld_d;
         end

         always_ff @(posedge clk) begin
            dat_q <= dat_d;
            tag_q <= tag_d;
         end

         assign fin_valid = vld_q[DEPTH-1];
         assign fin_data  = dat_q[DEPTH-1];
         assign fin_tag   = tag_q[DEPTH-1];
      end else begin : g_no_pipe
         assign fin_valid = pin_valid;
         assign fin_data  = pin_data;
         assign fin_tag   = pin_tag;
      end
   endgenerate

   // ---------------- Response FIFO: registered head + storage ----------------
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
   logic [DATA_WIDTH-1:0] fdat_q [RSP_QUEUE];
   logic [DATA_WIDTH-1:0] fdat_d [RSP_QUEUE];
   logic [TAG_WIDTH-1:0]  ftag_q [RSP_QUEUE];
   logic [TAG_WIDTH-1:0]  ftag_d [RSP_QUEUE];
   logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [OUT_W-1:0]      fcnt_q, fcnt_d;
   logic                  st_push, st_pop;

   // Head refills from storage first to keep accept order; empty storage falls straight through.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      fdat_d      = fdat_q;
      ftag_d      = ftag_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      fcnt_d      = fcnt_q;
      st_push     = 1'b0;
      st_pop      = 1'b0;
      if (!rsp_valid_q || rsp_pop) begin
         if (fcnt_q != '0) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = fdat_q[rptr_q];
            rsp_tag_d   = ftag_q[rptr_q];
            st_pop      = 1'b1;
            st_push     = fin_valid;
         end else begin
            rsp_valid_d = fin_valid;
            if (fin_valid) begin
               rsp_data_d = fin_data;
               rsp_tag_d  = fin_tag;
            end
         end
      end else begin
         st_push = fin_valid;
      end
      if (st_push) begin
         fdat_d[wptr_q] = fin_data;
         ftag_d[wptr_q] = fin_tag;
         wptr_d         = wptr_q + 1'b1;
      end
      if (st_pop) rptr_d = rptr_q + 1'b1;
      if (st_push && !st_pop)      fcnt_d = fcnt_q + 1'b1;
      else if (!st_push && st_pop) fcnt_d = fcnt_q - 1'b1;
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (slot_fire && !rsp_pop)      outstanding_d = outstanding_q + 1'b1;
      else if (!slot_fire && rsp_pop) outstanding_d = outstanding_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_tag_q     <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         fcnt_q        <= '0;
         outstanding_q <= '0;
      end else begin
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_tag_q     <= rsp_tag_d;
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         fcnt_q        <= fcnt_d;
         outstanding_q <= outstanding_d;
      end
   end

   always_ff @(posedge clk) begin
      fdat_q <= fdat_d;
      ftag_q <= ftag_d;
   end

   assign mem_rsp_valid = rsp_valid_q;
   assign mem_rsp_data  = rsp_data_q;
   assign mem_rsp_tag   = rsp_tag_q;
   assign outstanding   = outstanding_q;

endmodule
`default_nettype wire
